// File: rtl/round_timer.sv
// Countdown round timer: prescaled decrement from START_VAL to zero,
// with pause, no-limit mode, BCD digits, warning and expiry strobe.
module round_timer #(
    parameter int CNT_W     = 7,
    parameter int START_VAL = 99,
    parameter int TICK_DIV  = 50000000,
    parameter int WARN_VAL  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             keep,
    input  logic             start,
    input  logic             infinite,
    output logic [CNT_W-1:0] remain_t,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             warn,
    output logic             timeout,
    output logic             timeout_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] START_V   = CNT_W'(START_VAL);

    typedef enum logic {
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             timeout_q, timeout_d;
    logic             pulse_q, pulse_d;
    logic [31:0]      remain_w;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        remain_d  = remain_q;
        timeout_d = timeout_q;
        pulse_d   = 1'b0;
        if (start) begin
            state_d   = RUN;
            presc_d   = '0;
            remain_d  = START_V;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!keep && !infinite) begin
                        if (presc_q == PRESC_MAX) begin
                            presc_d = '0;
                            if (remain_q != '0) begin
                                remain_d = remain_q - 1'b1;
                            end
                            // expiry is the 1 -> 0 step
                            if (remain_q == CNT_W'(1)) begin
                                state_d   = DONE;
                                timeout_d = 1'b1;
                                pulse_d   = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    presc_d   = '0;
                    remain_d  = '0;
                    timeout_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            presc_q   <= '0;
            remain_q  <= START_V;
            timeout_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            remain_q  <= remain_d;
            timeout_q <= timeout_d;
            pulse_q   <= pulse_d;
        end
    end

    assign remain_w      = 32'(remain_q);
    assign remain_t      = remain_q;
    assign timeout       = timeout_q;
    assign timeout_pulse = pulse_q;

    // values beyond two digits saturate the display at 99
    always_comb begin
        tens = 4'd9;
        ones = 4'd9;
        if (remain_w <= 32'd99) begin
            tens = 4'(remain_w / 32'd10);
            ones = 4'(remain_w % 32'd10);
        end
    end

    assign warn = (remain_w <= unsigned'(WARN_VAL)) && !timeout_q && !infinite;

endmodule

// File: tb/tb_round_timer.sv
// Bench for round_timer: directed scenarios plus random control traffic,
// compared against an elapsed-edge arithmetic model.
module tb_round_timer;

    localparam int SA = 5;
    localparam int DA = 2;
    localparam int WA = 2;
    localparam int SB = 99;
    localparam int DB = 1;
    localparam int WB = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, keep_a = 1'b0, start_a = 1'b0, inf_a = 1'b0;
    logic [6:0] rem_a;
    logic [3:0] tens_a, ones_a;
    logic       warn_a, to_a, tp_a;

    logic       rst_b = 1'b0, keep_b = 1'b0, start_b = 1'b0, inf_b = 1'b0;
    logic [6:0] rem_b;
    logic [3:0] tens_b, ones_b;
    logic       warn_b, to_b, tp_b;

    int vectors = 0;
    int miscompares = 0;

    // model state: counting edges consumed since last reload
    int el_a = 0;
    int el_b = 0;
    bit pls_a = 1'b0;
    bit pls_b = 1'b0;

    round_timer #(
        .CNT_W(7), .START_VAL(SA), .TICK_DIV(DA), .WARN_VAL(WA)
    ) dut (
        .clk(clk), .reset(rst_a), .keep(keep_a), .start(start_a),
        .infinite(inf_a), .remain_t(rem_a), .tens(tens_a), .ones(ones_a),
        .warn(warn_a), .timeout(to_a), .timeout_pulse(tp_a)
    );

    round_timer #(
        .TICK_DIV(DB)
    ) dut_b (
        .clk(clk), .reset(rst_b), .keep(keep_b), .start(start_b),
        .infinite(inf_b), .remain_t(rem_b), .tens(tens_b), .ones(ones_b),
        .warn(warn_b), .timeout(to_b), .timeout_pulse(tp_b)
    );

    function automatic int rem_of(int el, int s, int d);
        return (el >= s * d) ? 0 : s - el / d;
    endfunction

    function automatic int tens_of(int r);
        return (r > 99) ? 9 : r / 10;
    endfunction

    function automatic int ones_of(int r);
        return (r > 99) ? 9 : r % 10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (!rst_a || start_a) begin
            el_a = 0;
            pls_a = 1'b0;
        end else if (el_a >= SA * DA || keep_a || inf_a) begin
            pls_a = 1'b0;
        end else begin
            el_a++;
            pls_a = (el_a == SA * DA);
        end
        if (!rst_b || start_b) begin
            el_b = 0;
            pls_b = 1'b0;
        end else if (el_b >= SB * DB || keep_b || inf_b) begin
            pls_b = 1'b0;
        end else begin
            el_b++;
            pls_b = (el_b == SB * DB);
        end
    endtask

    task automatic tick();
        int ra, rb;
        @(posedge clk);
        model_step();
        #1;
        ra = rem_of(el_a, SA, DA);
        rb = rem_of(el_b, SB, DB);
        chk("a_remain", 32'(rem_a), ra);
        chk("a_tens", 32'(tens_a), tens_of(ra));
        chk("a_ones", 32'(ones_a), ones_of(ra));
        chk("a_timeout", 32'(to_a), 32'(el_a >= SA * DA));
        chk("a_pulse", 32'(tp_a), 32'(pls_a));
        chk("a_warn", 32'(warn_a),
            32'(ra <= WA && el_a < SA * DA && !inf_a));
        chk("b_remain", 32'(rem_b), rb);
        chk("b_tens", 32'(tens_b), tens_of(rb));
        chk("b_ones", 32'(ones_b), ones_of(rb));
        chk("b_timeout", 32'(to_b), 32'(el_b >= SB * DB));
        chk("b_pulse", 32'(tp_b), 32'(pls_b));
        chk("b_warn", 32'(warn_b),
            32'(rb <= WB && el_b < SB * DB && !inf_b));
    endtask

    initial begin
        repeat (5) tick();
        chk("a_reset_val", 32'(rem_a), 5);
        chk("b_reset_digits", {24'd0, tens_b, ones_b}, 32'h99);
        rst_a = 1'b1;
        rst_b = 1'b1;

        repeat (9) tick();
        chk("a_before_expiry", 32'(to_a), 0);
        tick();
        chk("a_expiry_pulse", 32'(tp_a), 1);
        chk("a_expiry_level", 32'(to_a), 1);
        tick();
        chk("a_pulse_single", 32'(tp_a), 0);
        chk("a_done_hold", 32'(rem_a), 0);

        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a_restart_val", 32'(rem_a), 5);
        chk("a_restart_to", 32'(to_a), 0);

        for (int i = 0; i < 20 && rem_of(el_a, SA, DA) != 3; i++) tick();
        chk("a_reach3", 32'(rem_a), 3);
        keep_a = 1'b1;
        repeat (7) tick();
        chk("a_keep_hold", 32'(rem_a), 3);
        keep_a = 1'b0;
        tick();
        chk("a_keep_resume1", 32'(rem_a), 3);
        tick();
        chk("a_keep_resume2", 32'(rem_a), 2);

        keep_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a_start_over_keep", 32'(rem_a), 5);
        tick();
        chk("a_start_keep_hold", 32'(rem_a), 5);
        keep_a = 1'b0;

        for (int i = 0; i < 20 && rem_of(el_a, SA, DA) != 2; i++) tick();
        chk("a_reach2", 32'(rem_a), 2);
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        chk("a_midrun_reset", 32'(rem_a), 5);
        chk("a_midrun_reset_to", 32'(to_a), 0);

        for (int i = 0; i < 20 && rem_of(el_a, SA, DA) != 1; i++) tick();
        inf_a = 1'b1;
        repeat (20) tick();
        chk("a_inf_frozen", 32'(rem_a), 1);
        chk("a_inf_to", 32'(to_a), 0);
        chk("a_inf_warn", 32'(warn_a), 0);
        inf_a = 1'b0;

        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        repeat (42) tick();
        chk("b_rem57", 32'(rem_b), 57);
        chk("b_digits57", {24'd0, tens_b, ones_b}, 32'h57);
        repeat (56) tick();
        chk("b_pre_timeout", 32'(to_b), 0);
        tick();
        chk("b_timeout_99", 32'(to_b), 1);
        chk("b_pulse_99", 32'(tp_b), 1);

        for (int i = 0; i < 2000; i++) begin
            rst_a   = ($urandom_range(0, 63) != 0);
            start_a = ($urandom_range(0, 39) == 0);
            keep_a  = ($urandom_range(0, 3) == 0);
            inf_a   = ($urandom_range(0, 7) == 0);
            rst_b   = ($urandom_range(0, 499) != 0);
            start_b = ($urandom_range(0, 299) == 0);
            keep_b  = ($urandom_range(0, 3) == 0);
            inf_b   = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
